kiwi_run_directorate: RTL and testbench

- Run-control sequencer for a KiwiC-generated kernel, i.e. one exposing `hpr_abend_syndrome` with 255 meaning running, 0 meaning normal exit, and any other value an abend code.
- Holds the kernel in reset, releases it, and gates its run enable.
- Supports pause/resume, abort and a cycle watchdog, and reports completion status and run-cycle count to the host.
- Sits between the host control registers and the kernel's `reset` and run-enable inputs.

---
 rtl/kiwi_run_directorate.sv | 210 +++++++++++++++++++++
 tb/tb_kiwi_run_directorate.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/kiwi_run_directorate.sv
// kiwi_run_directorate: run-control sequencer for a KiwiC-generated kernel.
// Holds the kernel in reset, arms it, gates its run enable, and reports the
// final syndrome and the number of enabled kernel cycles back to the host.
module kiwi_run_directorate #(
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4,
  parameter int WDOG_LIMIT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause_req,
  input  logic             resume_req,
  input  logic             abort,
  input  logic [7:0]       dut_abend_syndrome,
  output logic             dut_reset,
  output logic             dut_run_enable,
  output logic             busy,
  output logic             done,
  output logic [7:0]       status_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [7:0]       unary_leds
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET_DUT,
    S_RUN,
    S_PAUSED,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [7:0] SYN_RUNNING  = 8'hFF;
  localparam logic [7:0] SYN_EXIT_OK  = 8'h00;
  localparam logic [7:0] CODE_OK      = 8'h00;
  localparam logic [7:0] CODE_NO_ARM  = 8'hFC;
  localparam logic [7:0] CODE_ABORT   = 8'hFD;
  localparam logic [7:0] CODE_WDOG    = 8'hFE;

  localparam int              RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);

  state_t           state, state_d;
  logic [RC_W-1:0]  rst_cnt, rst_cnt_d;
  logic             dut_reset_d;
  logic             run_enable_d;
  logic             busy_d;
  logic             done_d;
  logic [7:0]       status_d;
  logic [CNT_W-1:0] count_d;
  logic [7:0]       leds_d;

  logic syn_exit_ok;
  logic syn_abend;
  logic wdog_hit;

  function automatic logic [7:0] state_leds(input state_t s);
    logic [7:0] v;
    v = 8'h00;
    case (s)
      S_IDLE:      v = 8'h01;
      S_RESET_DUT: v = 8'h02;
      S_RUN:       v = 8'h04;
      S_PAUSED:    v = 8'h08;
      S_DONE:      v = 8'h10;
      S_FAULT:     v = 8'h20;
      default:     v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic is_terminal(input state_t s);
    return (s == S_DONE) || (s == S_FAULT);
  endfunction

  // Decode the kernel syndrome and the watchdog threshold for this cycle.
  always_comb begin
    syn_exit_ok = (dut_abend_syndrome == SYN_EXIT_OK);
    syn_abend   = (dut_abend_syndrome != SYN_EXIT_OK) && (dut_abend_syndrome != SYN_RUNNING);
    wdog_hit    = (WDOG_LIMIT != 0) && (cycle_count == WDOG_LAST)
                  && (dut_abend_syndrome == SYN_RUNNING);
  end

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d      = state;
    rst_cnt_d    = rst_cnt;
    dut_reset_d  = dut_reset;
    run_enable_d = dut_run_enable;
    status_d     = status_code;
    count_d      = cycle_count;

    // The kernel advances on every edge where the gate is open, including
    // the edge on which we leave RUN, so count from the registered enable.
    if (dut_run_enable && (cycle_count != '1)) begin
      count_d = cycle_count + 1'b1;
    end

    case (state)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          state_d      = S_RESET_DUT;
          rst_cnt_d    = '0;
          dut_reset_d  = 1'b1;
          run_enable_d = 1'b0;
          count_d      = '0;
          status_d     = CODE_OK;
        end
      end

      S_RESET_DUT: begin
        if (abort) begin
          state_d      = S_FAULT;
          status_d     = CODE_ABORT;
          dut_reset_d  = 1'b0;
          run_enable_d = 1'b0;
        end else if (rst_cnt == RC_LAST) begin
          dut_reset_d = 1'b0;
          if (dut_abend_syndrome != SYN_RUNNING) begin
            state_d      = S_FAULT;
            status_d     = CODE_NO_ARM;
            run_enable_d = 1'b0;
          end else begin
            state_d      = S_RUN;
            run_enable_d = 1'b1;
          end
        end else begin
          rst_cnt_d = rst_cnt + 1'b1;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d      = S_FAULT;
          status_d     = CODE_ABORT;
          run_enable_d = 1'b0;
        end else if (syn_exit_ok) begin
          state_d      = S_DONE;
          status_d     = CODE_OK;
          run_enable_d = 1'b0;
        end else if (syn_abend) begin
          state_d      = S_FAULT;
          status_d     = dut_abend_syndrome;
          run_enable_d = 1'b0;
        end else if (wdog_hit) begin
          state_d      = S_FAULT;
          status_d     = CODE_WDOG;
          run_enable_d = 1'b0;
        end else if (pause_req) begin
          state_d      = S_PAUSED;
          run_enable_d = 1'b0;
        end
      end

      S_PAUSED: begin
        if (abort) begin
          state_d  = S_FAULT;
          status_d = CODE_ABORT;
        end else if (syn_exit_ok) begin
          state_d  = S_DONE;
          status_d = CODE_OK;
        end else if (syn_abend) begin
          state_d  = S_FAULT;
          status_d = dut_abend_syndrome;
        end else if (resume_req) begin
          state_d      = S_RUN;
          run_enable_d = 1'b1;
        end
      end

      default: begin
        state_d      = S_IDLE;
        dut_reset_d  = 1'b1;
        run_enable_d = 1'b0;
      end
    endcase

    busy_d = (state_d == S_RESET_DUT) || (state_d == S_RUN) || (state_d == S_PAUSED);
    done_d = is_terminal(state_d) && !is_terminal(state);
    leds_d = state_leds(state_d);
  end

  // State and output registers; reset parks the kernel in reset immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      rst_cnt        <= '0;
      dut_reset      <= 1'b1;
      dut_run_enable <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      status_code    <= 8'h00;
      cycle_count    <= '0;
      unary_leds     <= 8'h01;
    end else begin
      state          <= state_d;
      rst_cnt        <= rst_cnt_d;
      dut_reset      <= dut_reset_d;
      dut_run_enable <= run_enable_d;
      busy           <= busy_d;
      done           <= done_d;
      status_code    <= status_d;
      cycle_count    <= count_d;
      unary_leds     <= leds_d;
    end
  end

endmodule

// File: tb/tb_kiwi_run_directorate.sv
// tb_kiwi_run_directorate: directed bench for the kernel run sequencer,
// with a small kernel model that counts enabled edges and raises its
// syndrome after a programmed number of them.
module tb_kiwi_run_directorate;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, pause_req, resume_req, abort;
  logic [7:0]  dut_abend_syndrome;
  logic        dut_reset, dut_run_enable, busy, done;
  logic [7:0]  status_code;
  logic [31:0] cycle_count;
  logic [7:0]  unary_leds;

  int          check_count = 0;
  int          pass_count  = 0;
  int          k_edges     = 0;
  int          en_total    = 0;
  int          exit_at     = 0;
  logic [7:0]  exit_code   = 8'h00;
  logic        override_en = 1'b0;
  logic [7:0]  override_val = 8'hFF;
  int          en_before;

  kiwi_run_directorate #(
    .CNT_W(32),
    .RST_CYCLES(4),
    .WDOG_LIMIT(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pause_req(pause_req),
    .resume_req(resume_req),
    .abort(abort),
    .dut_abend_syndrome(dut_abend_syndrome),
    .dut_reset(dut_reset),
    .dut_run_enable(dut_run_enable),
    .busy(busy),
    .done(done),
    .status_code(status_code),
    .cycle_count(cycle_count),
    .unary_leds(unary_leds)
  );

  always #5 clk = ~clk;

  // Kernel model: synchronous reset, advances only while the gate is open.
  always @(posedge clk or posedge reset) begin
    if (reset)               k_edges <= 0;
    else if (dut_reset)      k_edges <= 0;
    else if (dut_run_enable) k_edges <= k_edges + 1;
  end

  // Running total of edges seen with the run gate open.
  always @(posedge clk) begin
    if (dut_run_enable) en_total <= en_total + 1;
  end

  assign dut_abend_syndrome = override_en ? override_val :
                              ((exit_at != 0 && k_edges >= exit_at) ? exit_code : 8'hFF);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  // Drive one set of request pulses across exactly one rising edge.
  task automatic applyStimulus(input logic s, input logic p, input logic r, input logic a);
    start = s; pause_req = p; resume_req = r; abort = a;
    @(negedge clk);
    start = 1'b0; pause_req = 1'b0; resume_req = 1'b0; abort = 1'b0;
  endtask

  task automatic waitLeds(input string tag, input logic [7:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (unary_leds == target) break;
      @(negedge clk);
    end
    checkOutput(tag, {24'h0, unary_leds}, {24'h0, target});
  endtask

  task automatic waitCount(input string tag, input logic [31:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cycle_count == target) break;
      @(negedge clk);
    end
    checkOutput(tag, cycle_count, target);
  endtask

  // Hard stop in case something upstream hangs the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed hang, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    start = 1'b0; pause_req = 1'b0; resume_req = 1'b0; abort = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_dut_reset", {31'h0, dut_reset}, 32'h1);
    checkOutput("rst_run_en", {31'h0, dut_run_enable}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_status", {24'h0, status_code}, 32'h0);
    checkOutput("rst_count", cycle_count, 32'h0);
    checkOutput("rst_leds", {24'h0, unary_leds}, 32'h01);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // Normal run: exit code 0 after 40 enabled edges
    exit_at = 40; exit_code = 8'h00;
    en_before = en_total;
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("norm_rst_hold", {31'h0, dut_reset}, 32'h1);
      checkOutput("norm_leds_rstdut", {24'h0, unary_leds}, 32'h02);
      @(negedge clk);
    end
    checkOutput("norm_rst_release", {31'h0, dut_reset}, 32'h0);
    checkOutput("norm_run_en", {31'h0, dut_run_enable}, 32'h1);
    checkOutput("norm_leds_run", {24'h0, unary_leds}, 32'h04);
    checkOutput("norm_busy", {31'h0, busy}, 32'h1);
    waitLeds("norm_done_state", 8'h10, 200);
    checkOutput("norm_done_pulse", {31'h0, done}, 32'h1);
    checkOutput("norm_status", {24'h0, status_code}, 32'h00);
    checkOutput("norm_count", cycle_count, 32'd41);
    checkOutput("norm_en_cycles", en_total - en_before, 32'd41);
    checkOutput("norm_busy_off", {31'h0, busy}, 32'h0);
    @(negedge clk);
    checkOutput("norm_done_single", {31'h0, done}, 32'h0);
    checkOutput("norm_hold_reset_low", {31'h0, dut_reset}, 32'h0);

    // Kernel abend 0x03 after 10 enabled edges; start mid-run ignored
    exit_at = 10; exit_code = 8'h03;
    applyStimulus(1, 0, 0, 0);
    checkOutput("abend_restart_status", {24'h0, status_code}, 32'h00);
    checkOutput("abend_restart_count", cycle_count, 32'h0);
    waitLeds("abend_run", 8'h04, 20);
    applyStimulus(1, 0, 0, 0);
    checkOutput("abend_start_ignored", {24'h0, unary_leds}, 32'h04);
    waitLeds("abend_fault", 8'h20, 50);
    checkOutput("abend_status", {24'h0, status_code}, 32'h03);
    checkOutput("abend_count", cycle_count, 32'd11);
    checkOutput("abend_busy", {31'h0, busy}, 32'h0);

    // Watchdog: syndrome never leaves 0xFF
    exit_at = 0;
    en_before = en_total;
    applyStimulus(1, 0, 0, 0);
    waitLeds("wdog_fault", 8'h20, 300);
    checkOutput("wdog_status", {24'h0, status_code}, 32'hFE);
    checkOutput("wdog_count", cycle_count, 32'd100);
    checkOutput("wdog_run_en_off", {31'h0, dut_run_enable}, 32'h0);
    checkOutput("wdog_en_cycles", en_total - en_before, 32'd100);

    // Pause at count 20, hold 15 cycles, resume with both requests high
    exit_at = 40; exit_code = 8'h00;
    applyStimulus(1, 0, 0, 0);
    waitCount("pause_reach20", 32'd20, 100);
    applyStimulus(0, 1, 0, 0);
    checkOutput("pause_leds", {24'h0, unary_leds}, 32'h08);
    checkOutput("pause_run_en", {31'h0, dut_run_enable}, 32'h0);
    checkOutput("pause_count_entry", cycle_count, 32'd21);
    for (int i = 0; i < 14; i++) @(negedge clk);
    checkOutput("pause_count_frozen", cycle_count, 32'd21);
    checkOutput("pause_still_paused", {24'h0, unary_leds}, 32'h08);
    applyStimulus(0, 1, 1, 0);
    checkOutput("resume_leds", {24'h0, unary_leds}, 32'h04);
    checkOutput("resume_run_en", {31'h0, dut_run_enable}, 32'h1);
    waitLeds("pause_done", 8'h10, 100);
    checkOutput("pause_final_count", cycle_count, 32'd41);
    checkOutput("pause_final_status", {24'h0, status_code}, 32'h00);

    // Abort while the kernel is being held in reset
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("abort_rst_leds", {24'h0, unary_leds}, 32'h20);
    checkOutput("abort_rst_status", {24'h0, status_code}, 32'hFD);
    checkOutput("abort_rst_dut_reset", {31'h0, dut_reset}, 32'h0);
    checkOutput("abort_rst_done", {31'h0, done}, 32'h1);

    // Abort on the same cycle the syndrome reaches 0x00
    exit_at = 5; exit_code = 8'h00;
    applyStimulus(1, 0, 0, 0);
    waitCount("abort_sync_reach5", 32'd5, 30);
    applyStimulus(0, 0, 0, 1);
    checkOutput("abort_sync_leds", {24'h0, unary_leds}, 32'h20);
    checkOutput("abort_sync_status", {24'h0, status_code}, 32'hFD);
    checkOutput("abort_sync_count", cycle_count, 32'd6);

    // Kernel fails to arm: syndrome 0x12 during reset hold
    override_en = 1'b1; override_val = 8'h12;
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("noarm_leds_rstdut", {24'h0, unary_leds}, 32'h02);
      @(negedge clk);
    end
    checkOutput("noarm_leds", {24'h0, unary_leds}, 32'h20);
    checkOutput("noarm_status", {24'h0, status_code}, 32'hFC);
    checkOutput("noarm_count", cycle_count, 32'h0);
    override_en = 1'b0;

    // Asynchronous reset between edges while running
    exit_at = 0;
    applyStimulus(1, 0, 0, 0);
    waitLeds("areset_run", 8'h04, 20);
    for (int i = 0; i < 5; i++) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("areset_dut_reset", {31'h0, dut_reset}, 32'h1);
    checkOutput("areset_run_en", {31'h0, dut_run_enable}, 32'h0);
    checkOutput("areset_leds", {24'h0, unary_leds}, 32'h01);
    checkOutput("areset_count", cycle_count, 32'h0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    exit_at = 40; exit_code = 8'h00;
    applyStimulus(1, 0, 0, 0);
    waitLeds("clean_done", 8'h10, 200);
    checkOutput("clean_count", cycle_count, 32'd41);
    checkOutput("clean_status", {24'h0, status_code}, 32'h00);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
